// File: rtl/msb_stream_gen.sv
// ----------------------------------------------------------------------------
// msb_stream_gen
// Pseudo-random bit-stream source built on a Fibonacci LFSR. While running it
// emits the register MSB once per clock (free-running or a fixed-length burst)
// and flags the end of every full LFSR period so downstream zero/one balance
// can be checked.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        begin emitting (sampled in IDLE)
//   stop         halt emission, LFSR and bit count preserved (sampled in RUN)
//   burst_len    bits per start, 0 = free-running (latched on start)
//   seed_load    load seed_in into the LFSR (IDLE only)
//   seed_in      seed value, zero is rejected
//   seed_ack     1-cycle pulse, seed accepted
//   seed_err     1-cycle pulse, zero seed rejected
//   msb          emitted bit
//   msb_valid    msb holds a fresh sample this cycle
//   period_done  pulses with the (2^WIDTH-1)th bit since seed/reset
//   busy         high while running
//   lfsr_state   current LFSR register
// ----------------------------------------------------------------------------
module msb_stream_gen #(
   parameter int unsigned      WIDTH        = 17,
   parameter logic [WIDTH-1:0] TAPS         = WIDTH'(17'h12000),
   parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(17'h00001)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic [WIDTH-1:0] burst_len,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_in,
   output logic             seed_ack,
   output logic             seed_err,
   output logic             msb,
   output logic             msb_valid,
   output logic             period_done,
   output logic             busy,
   output logic [WIDTH-1:0] lfsr_state
);

   typedef enum logic {IDLE, RUN} state_t;

   // Last bit count of a maximal-length period: 2^WIDTH-1.
   localparam logic [WIDTH-1:0] PERIOD_LAST = '1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] lfsr_q, lfsr_d;
   logic [WIDTH-1:0] bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] burst_cnt_q, burst_cnt_d;
   logic [WIDTH-1:0] burst_len_q, burst_len_d;
   logic             msb_q, msb_d;
   logic             msb_valid_q, msb_valid_d;
   logic             period_done_q, period_done_d;
   logic             busy_q, busy_d;
   logic             seed_ack_q, seed_ack_d;
   logic             seed_err_q, seed_err_d;

   logic             fb;
   logic [WIDTH-1:0] bit_cnt_inc;
   logic [WIDTH-1:0] burst_cnt_inc;

   assign fb            = ^(lfsr_q & TAPS);
   assign bit_cnt_inc   = bit_cnt_q + WIDTH'(1);
   assign burst_cnt_inc = burst_cnt_q + WIDTH'(1);

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         lfsr_q        <= DEFAULT_SEED;
         bit_cnt_q     <= '0;
         burst_cnt_q   <= '0;
         burst_len_q   <= '0;
         msb_q         <= 1'b0;
         msb_valid_q   <= 1'b0;
         period_done_q <= 1'b0;
         busy_q        <= 1'b0;
         seed_ack_q    <= 1'b0;
         seed_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         lfsr_q        <= lfsr_d;
         bit_cnt_q     <= bit_cnt_d;
         burst_cnt_q   <= burst_cnt_d;
         burst_len_q   <= burst_len_d;
         msb_q         <= msb_d;
         msb_valid_q   <= msb_valid_d;
         period_done_q <= period_done_d;
         busy_q        <= busy_d;
         seed_ack_q    <= seed_ack_d;
         seed_err_q    <= seed_err_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d       = state_q;
      lfsr_d        = lfsr_q;
      bit_cnt_d     = bit_cnt_q;
      burst_cnt_d   = burst_cnt_q;
      burst_len_d   = burst_len_q;
      msb_d         = msb_q;
      msb_valid_d   = 1'b0;
      period_done_d = 1'b0;
      seed_ack_d    = 1'b0;
      seed_err_d    = 1'b0;

      case (state_q)
         IDLE: begin
            // seed_load outranks stop, which outranks start.
            if (seed_load) begin
               if (seed_in != '0) begin
                  lfsr_d     = seed_in;
                  bit_cnt_d  = '0;
                  seed_ack_d = 1'b1;
               end else begin
                  seed_err_d = 1'b1;
               end
            end else if (!stop && start) begin
               state_d     = RUN;
               burst_len_d = burst_len;
               burst_cnt_d = '0;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
            end else begin
               msb_d       = lfsr_q[WIDTH-1];
               msb_valid_d = 1'b1;
               lfsr_d      = {lfsr_q[WIDTH-2:0], fb};
               burst_cnt_d = burst_cnt_inc;
               if (bit_cnt_inc == PERIOD_LAST) begin
                  bit_cnt_d     = '0;
                  period_done_d = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_inc;
               end
               // The final burst bit is still emitted on the exit edge.
               if ((burst_len_q != '0) && (burst_cnt_inc == burst_len_q)) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RUN);
   end

   assign msb         = msb_q;
   assign msb_valid   = msb_valid_q;
   assign period_done = period_done_q;
   assign busy        = busy_q;
   assign seed_ack    = seed_ack_q;
   assign seed_err    = seed_err_q;
   assign lfsr_state  = lfsr_q;

endmodule
